// File: rtl/lcd_reg_display_pkg.sv
// Shared definitions for lcd_reg_display: FSM state encodings, ASCII constants, line lengths.
package lcd_reg_display_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SNAP     = 3'd1;
    localparam logic [2:0] ST_CLR      = 3'd2;
    localparam logic [2:0] ST_CLR_WAIT = 3'd3;
    localparam logic [2:0] ST_LOAD     = 3'd4;
    localparam logic [2:0] ST_WRITE    = 3'd5;
    localparam logic [2:0] ST_WR_WAIT  = 3'd6;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_X     = 8'h58;
    localparam logic [7:0] CH_Y     = 8'h59;
    localparam logic [7:0] CH_O     = 8'h4F;
    localparam logic [7:0] CH_P     = 8'h50;

    localparam int unsigned NCHARS_BASE  = 19;
    localparam int unsigned NCHARS_FLAGS = 24;

endpackage

// File: rtl/lcd_reg_display_if.sv
// Character/clear handshake between lcd_reg_display (master) and lcd_control (slave).
interface lcd_reg_display_if;

    logic [7:0] data;
    logic       writeStart;
    logic       clrLCD;
    logic       initDone;
    logic       writeDone;

    modport master (output data, writeStart, clrLCD, input initDone, writeDone);
    modport slave  (input data, writeStart, clrLCD, output initDone, writeDone);

endinterface

// File: rtl/lcd_reg_display_nib_to_ascii.sv
// Combinational 4-bit nibble to uppercase hex ASCII digit.
module nib_to_ascii
    import lcd_reg_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ch
);

    always_comb begin
        if (nib < 4'd10)
            ch = CH_ZERO + {4'h0, nib};
        else
            ch = CH_A + {4'h0, nib} - 8'd10;
    end

endmodule

// File: rtl/lcd_reg_display.sv
// Snapshots CPU register taps on each display strobe and streams "A=hh X=hh Y=hh O=hh" to lcd_control.
// Define LCD_REG_DISPLAY_SHOW_FLAGS_EN to append " P=hh" from the status flags.
module lcd_reg_display
    import lcd_reg_display_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1048576,
    parameter int unsigned TW          = 21
) (
    input  logic                   clk,
    input  logic                   rst_L,
    input  logic                   display,
    input  logic [7:0]             A,
    input  logic [7:0]             X,
    input  logic [7:0]             Y,
    input  logic [7:0]             OP,
    input  logic [7:0]             P,
    lcd_reg_display_if.master      lcd,
    output logic                   busy,
    output logic                   err
);

`ifdef LCD_REG_DISPLAY_SHOW_FLAGS_EN
    localparam int unsigned NCHARS = NCHARS_FLAGS;
`else
    localparam int unsigned NCHARS = NCHARS_BASE;
`endif
    localparam logic [4:0]    LAST_IDX  = 5'(NCHARS - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   strobe_edge;
    logic                   pending;
    logic [2:0]             state;
    logic [4:0]             idx;
    logic [TW-1:0]          timer;
    logic [7:0]             snap_a, snap_x, snap_y, snap_op;
    logic [7:0]             data_q;
    logic [7:0]             sel_byte, letter, hi_ch, lo_ch, line_ch;
    logic [4:0]             pos;

`ifdef LCD_REG_DISPLAY_SHOW_FLAGS_EN
    logic [7:0] snap_p;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L)
            snap_p <= '0;
        else if (state == ST_SNAP)
            snap_p <= P;
    end
`else
    logic unused_p;
    assign unused_p = ^P;
`endif

    // The edge detect compares against a delayed copy, so pending rises one edge after the sync chain.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= display;
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strobe_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

    // A new edge wins over the clear in SNAP so a request arriving then is not lost.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L)
            pending <= 1'b0;
        else if (strobe_edge)
            pending <= 1'b1;
        else if (state == ST_SNAP)
            pending <= 1'b0;
    end

    always_comb begin
        sel_byte = snap_a;
        letter   = CH_A;
        pos      = idx;
        if (idx < 5'd5) begin
            sel_byte = snap_a;
            letter   = CH_A;
            pos      = idx;
        end else if (idx < 5'd10) begin
            sel_byte = snap_x;
            letter   = CH_X;
            pos      = idx - 5'd5;
        end else if (idx < 5'd15) begin
            sel_byte = snap_y;
            letter   = CH_Y;
            pos      = idx - 5'd10;
`ifdef LCD_REG_DISPLAY_SHOW_FLAGS_EN
        end else if (idx < 5'd20) begin
            sel_byte = snap_op;
            letter   = CH_O;
            pos      = idx - 5'd15;
        end else begin
            sel_byte = snap_p;
            letter   = CH_P;
            pos      = idx - 5'd20;
        end
`else
        end else begin
            sel_byte = snap_op;
            letter   = CH_O;
            pos      = idx - 5'd15;
        end
`endif
    end

    nib_to_ascii u_nib_hi (.nib(sel_byte[7:4]), .ch(hi_ch));
    nib_to_ascii u_nib_lo (.nib(sel_byte[3:0]), .ch(lo_ch));

    always_comb begin
        case (pos)
            5'd0:    line_ch = letter;
            5'd1:    line_ch = CH_EQ;
            5'd2:    line_ch = hi_ch;
            5'd3:    line_ch = lo_ch;
            default: line_ch = CH_SPACE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= ST_IDLE;
            idx     <= '0;
            timer   <= '0;
            snap_a  <= '0;
            snap_x  <= '0;
            snap_y  <= '0;
            snap_op <= '0;
            data_q  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending && lcd.initDone)
                        state <= ST_SNAP;
                end
                ST_SNAP: begin
                    snap_a  <= A;
                    snap_x  <= X;
                    snap_y  <= Y;
                    snap_op <= OP;
                    state   <= ST_CLR;
                end
                ST_CLR: begin
                    timer <= '0;
                    state <= ST_CLR_WAIT;
                end
                ST_CLR_WAIT: begin
                    if (lcd.writeDone) begin
                        idx   <= '0;
                        state <= ST_LOAD;
                    end else if (timer == TIMER_MAX) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_LOAD: begin
                    data_q <= line_ch;
                    state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    timer <= '0;
                    state <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (lcd.writeDone) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end else if (timer == TIMER_MAX) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign lcd.data       = data_q;
    assign lcd.writeStart = (state == ST_WRITE);
    assign lcd.clrLCD     = (state == ST_CLR);
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_reg_display.sv
// Scoreboard bench for lcd_reg_display: expected lines are formatted with $sformatf and queued,
// a negedge monitor pops and compares every clrLCD / writeStart the DUT issues.
module tb_lcd_reg_display;

    localparam int unsigned SYNC = 2;
    localparam int unsigned TO   = 64;
`ifdef LCD_REG_DISPLAY_SHOW_FLAGS_EN
    localparam int NCH = 24;
`else
    localparam int NCH = 19;
`endif

    logic       clk = 1'b0;
    logic       rst_L = 1'b0;
    logic       display = 1'b0;
    logic [7:0] A, X, Y, OP, P;
    logic       busy, err;

    lcd_reg_display_if lcd_bus ();

    lcd_reg_display #(
        .SYNC_STAGES(SYNC),
        .TIMEOUT    (TO),
        .TW         (7)
    ) dut (
        .clk    (clk),
        .rst_L  (rst_L),
        .display(display),
        .A      (A),
        .X      (X),
        .Y      (Y),
        .OP     (OP),
        .P      (P),
        .lcd    (lcd_bus),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];
    int         cyc = 0;
    int         act_cnt = 0;
    int         clr_cnt = 0;
    int         ws_in_line = 0;
    int         last_ws_cyc = 0;
    bit         stall_mode = 0;
    int         cd = 0;
    int         m_ws = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic pop_check(input string nm, input logic [8:0] act);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got unexpected %0h expected nothing", nm, act);
        end else begin
            check(nm, {23'd0, act}, {23'd0, exp_q.pop_front()});
        end
    endtask

    // Reference: the whole line as text; 9'h100 marks the clear that precedes it.
    task automatic push_line(input logic [7:0] a, x, y, op, p, input int keep);
        string s;
        int    n;
        s = $sformatf("A=%02h X=%02h Y=%02h O=%02h", a, x, y, op);
`ifdef LCD_REG_DISPLAY_SHOW_FLAGS_EN
        s = {s, $sformatf(" P=%02h", p)};
`endif
        s = s.toupper();
        n = (keep == 0) ? s.len() : keep;
        exp_q.push_back(9'h100);
        for (int i = 0; i < n; i++)
            exp_q.push_back({1'b0, s.getc(i)});
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst_L) begin
            if (lcd_bus.clrLCD) begin
                clr_cnt++;
                act_cnt++;
                ws_in_line = 0;
                pop_check("clr", 9'h100);
            end
            if (lcd_bus.writeStart) begin
                act_cnt++;
                ws_in_line++;
                last_ws_cyc = cyc;
                pop_check("char", {1'b0, lcd_bus.data});
            end
        end
    end

    // lcd_control model: writeDone pulses 5 cycles after each request; ignores reset on purpose.
    initial forever begin
        @(negedge clk);
        lcd_bus.writeDone = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0)
                lcd_bus.writeDone = 1'b1;
        end
        if (rst_L) begin
            if (lcd_bus.clrLCD) begin
                m_ws = 0;
                cd = 5;
            end
            if (lcd_bus.writeStart) begin
                m_ws++;
                if (!(stall_mode && m_ws >= 4))
                    cd = 5;
            end
        end
    end

    task automatic pulse();
        @(negedge clk);
        display = 1'b1;
        repeat (4) @(negedge clk);
        display = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || busy) && n < maxc);
        if (n >= maxc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles, required idle", nm, n);
        end
    endtask

    task automatic edges_to_clr(input int expv, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!lcd_bus.clrLCD && n < 50);
        check(nm, n, expv);
    endtask

    task automatic rand_regs();
        A  = 8'($urandom);
        X  = 8'($urandom);
        Y  = 8'($urandom);
        OP = 8'($urandom);
        P  = 8'($urandom);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_data"}, {24'd0, lcd_bus.data}, 0);
        check({nm, "_ws"}, {31'd0, lcd_bus.writeStart}, 0);
        check({nm, "_clr"}, {31'd0, lcd_bus.clrLCD}, 0);
        check({nm, "_busy"}, {31'd0, busy}, 0);
        check({nm, "_err"}, {31'd0, err}, 0);
    endtask

    initial begin
        int c0, a0, n;
        A = 0; X = 0; Y = 0; OP = 0; P = 0;
        lcd_bus.initDone  = 1'b0;
        lcd_bus.writeDone = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_L = 1'b1;
        lcd_bus.initDone = 1'b1;
        repeat (3) @(negedge clk);

        // Directed line with strobe-to-clear latency and end-of-line busy timing
        A = 8'h3F; X = 8'h00; Y = 8'h80; OP = 8'hA9; P = 8'h30;
        push_line(A, X, Y, OP, P, 0);
        @(negedge clk);
        display = 1'b1;
        edges_to_clr(SYNC + 3, "latency");
        display = 1'b0;
        wait_drain(1000, "line1");
        check("line1_len", ws_in_line, NCH);
        check("busy_fall", cyc - last_ws_cyc, 6);

        for (int k = 0; k < 6; k++) begin
            rand_regs();
            push_line(A, X, Y, OP, P, 0);
            repeat ($urandom_range(0, 7)) @(negedge clk);
            pulse();
            wait_drain(1000, "rand_line");
            check("rand_len", ws_in_line, NCH);
        end

        // Three strobes during one line: one more line, with the values present at its SNAP
        c0 = clr_cnt;
        rand_regs();
        push_line(A, X, Y, OP, P, 0);
        pulse();
        for (int k = 0; k < 3; k++) begin
            rand_regs();
            pulse();
        end
        push_line(A, X, Y, OP, P, 0);
        wait_drain(2000, "b2b");
        repeat (30) @(posedge clk);
        #1;
        check("b2b_lines", clr_cnt - c0, 2);

        // Init gating
        @(negedge clk);
        lcd_bus.initDone = 1'b0;
        rand_regs();
        push_line(A, X, Y, OP, P, 0);
        c0 = clr_cnt;
        pulse();
        repeat (100) @(posedge clk);
        #1;
        check("gate_clr", clr_cnt - c0, 0);
        check("gate_busy", {31'd0, busy}, 0);
        @(negedge clk);
        lcd_bus.initDone = 1'b1;
        edges_to_clr(2, "init_latency");
        wait_drain(1000, "gate_line");

        // Timeout on the 4th character
        stall_mode = 1;
        rand_regs();
        push_line(A, X, Y, OP, P, 4);
        pulse();
        wait_drain(1000, "timeout");
        check("timeout_cycles", cyc - last_ws_cyc, TO + 1);
        check("timeout_err", {31'd0, err}, 1);
        check("timeout_busy", {31'd0, busy}, 0);
        check("timeout_ws", ws_in_line, 4);
        stall_mode = 0;
        rand_regs();
        push_line(A, X, Y, OP, P, 0);
        pulse();
        wait_drain(1000, "after_timeout");
        check("after_timeout_len", ws_in_line, NCH);
        check("err_sticky", {31'd0, err}, 1);

        // Reset during the 10th character
        rand_regs();
        push_line(A, X, Y, OP, P, 0);
        pulse();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ws_in_line != 10 && n < 1000);
        check("reach_char10", ws_in_line, 10);
        rst_L = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        a0 = act_cnt;
        repeat (2) @(negedge clk);
        rst_L = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("late_done_activity", act_cnt - a0, 0);
        check("late_done_busy", {31'd0, busy}, 0);
        rand_regs();
        push_line(A, X, Y, OP, P, 0);
        pulse();
        wait_drain(1000, "post_reset");
        check("post_reset_len", ws_in_line, NCH);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
